// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style fetch/control slice: FSM states,
// opcode constants and instruction field positions.
package mips_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [5:0] HALT_OPCODE = 6'h3F;

  localparam logic [5:0] OP_RTYPE  = 6'd0;
  localparam logic [5:0] OP_LW     = 6'd1;
  localparam logic [5:0] OP_SW     = 6'd2;
  localparam logic [5:0] OP_BRANCH = 6'd3;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Program-load, branch-control and decoded-instruction signals of the fetch unit.
// master = environment / control side, slave = the fetch unit itself.
interface instr_fetch_unit_if #(
  parameter int IMEM_DEPTH = 64
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic          run;
  logic          Branch;
  logic          Zero;

  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic [31:0]   instr;
  logic          instr_valid;
  logic [5:0]    Opcode;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [5:0]    funct;
  logic [31:0]   imm_sext;
  logic          halted;
  logic [31:0]   instr_count;

  modport master (
    output prog_we, prog_addr, prog_data, run, Branch, Zero,
    input  pc, pc_plus4, instr, instr_valid, Opcode, rs, rt, rd, funct,
           imm_sext, halted, instr_count
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, run, Branch, Zero,
    output pc, pc_plus4, instr, instr_valid, Opcode, rs, rt, rd, funct,
           imm_sext, halted, instr_count
  );

endinterface

// File: rtl/imem_rf.sv
// Instruction memory: DEPTH x 32 words, synchronous write, asynchronous read.
module imem_rf #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM and a loaded program survives rst_n.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// PC register, instruction memory, field split and LOAD/RUN/HALT sequencing
// feeding the single-cycle control unit.
module instr_fetch_unit #(
  parameter int          IMEM_DEPTH  = 64,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = mips_pkg::HALT_OPCODE
) (
  input logic              clk,
  input logic              rst_n,
  instr_fetch_unit_if.slave bus
);

  localparam int AW = $clog2(IMEM_DEPTH);

  mips_pkg::state_t state;
  logic        instr_valid;
  logic        halted;
  logic [31:0] pc;
  logic [31:0] instr_count;

  logic [31:0] rd_data;
  logic [31:0] instr;
  logic [31:0] imm_sext;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        take_branch;
  logic        is_halt_op;
  logic        out_of_range;
  logic        mem_we;

  assign mem_we = bus.prog_we && (state == mips_pkg::LOAD);

  imem_rf #(
    .DEPTH (IMEM_DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .raddr (pc[AW+1:2]),
    .rdata (rd_data)
  );

  // Outside RUN the decoder sees an all-zero word so nothing downstream fires.
  assign instr    = instr_valid ? rd_data : 32'h0;
  assign imm_sext = {{16{instr[mips_pkg::IMM_MSB]}}, instr[mips_pkg::IMM_MSB:mips_pkg::IMM_LSB]};

  assign pc_plus4     = pc + 32'd4;
  assign take_branch  = bus.Branch && bus.Zero;
  assign next_pc      = take_branch ? pc_plus4 + {imm_sext[29:0], 2'b00} : pc_plus4;
  assign is_halt_op   = instr[mips_pkg::OPCODE_MSB:mips_pkg::OPCODE_LSB] == HALT_OPCODE;
  assign out_of_range = next_pc[31:2] >= 30'(IMEM_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= mips_pkg::LOAD;
      pc          <= RESET_PC;
      instr_count <= 32'h0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        mips_pkg::LOAD: begin
          if (bus.run) begin
            state       <= mips_pkg::RUN;
            instr_valid <= 1'b1;
          end
        end
        mips_pkg::RUN: begin
          if (is_halt_op) begin
            // The halt word itself is neither retired nor stepped past.
            state       <= mips_pkg::HALT;
            instr_valid <= 1'b0;
            halted      <= 1'b1;
          end else begin
            if (instr_count != 32'hFFFF_FFFF) instr_count <= instr_count + 32'd1;
            if (out_of_range) begin
              state       <= mips_pkg::HALT;
              instr_valid <= 1'b0;
              halted      <= 1'b1;
            end else begin
              pc <= next_pc;
            end
          end
        end
        mips_pkg::HALT: begin
        end
        default: begin
          state       <= mips_pkg::LOAD;
          instr_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc          = pc;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.instr       = instr;
  assign bus.instr_valid = instr_valid;
  assign bus.Opcode      = instr[mips_pkg::OPCODE_MSB:mips_pkg::OPCODE_LSB];
  assign bus.rs          = instr[mips_pkg::RS_MSB:mips_pkg::RS_LSB];
  assign bus.rt          = instr[mips_pkg::RT_MSB:mips_pkg::RT_LSB];
  assign bus.rd          = instr[mips_pkg::RD_MSB:mips_pkg::RD_LSB];
  assign bus.funct       = instr[mips_pkg::FUNCT_MSB:mips_pkg::FUNCT_LSB];
  assign bus.imm_sext    = imm_sext;
  assign bus.halted      = halted;
  assign bus.instr_count = instr_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a 64-word instance for load/run/branch/
// halt/reset cases and a 4-word instance for running off the end of memory.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.IMEM_DEPTH(64)) a_if ();
  instr_fetch_unit_if #(.IMEM_DEPTH(4))  b_if ();

  instr_fetch_unit #(.IMEM_DEPTH(64), .RESET_PC(32'h0), .HALT_OPCODE(6'h3F)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  instr_fetch_unit #(.IMEM_DEPTH(4), .RESET_PC(32'h0), .HALT_OPCODE(6'h3F)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic load_a(input int addr, input logic [31:0] data);
    logic [5:0] a6;
    a6 = addr[5:0];
    a_if.prog_we   = 1'b1;
    a_if.prog_addr = a6;
    a_if.prog_data = data;
    step();
    a_if.prog_we   = 1'b0;
  endtask

  task automatic load_b(input int addr, input logic [31:0] data);
    logic [1:0] a2;
    a2 = addr[1:0];
    b_if.prog_we   = 1'b1;
    b_if.prog_addr = a2;
    b_if.prog_data = data;
    step();
    b_if.prog_we   = 1'b0;
  endtask

  task automatic start_a();
    a_if.run = 1'b1;
    step();
    a_if.run = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    a_if.prog_we = 1'b0; a_if.prog_addr = '0; a_if.prog_data = '0;
    a_if.run = 1'b0; a_if.Branch = 1'b0; a_if.Zero = 1'b0;
    b_if.prog_we = 1'b0; b_if.prog_addr = '0; b_if.prog_data = '0;
    b_if.run = 1'b0; b_if.Branch = 1'b0; b_if.Zero = 1'b0;

    // Reset values
    #2;
    check("rst_pc",          a_if.pc,          32'h0);
    check("rst_pc_plus4",    a_if.pc_plus4,    32'h4);
    check("rst_instr_valid", 32'(a_if.instr_valid), 32'h0);
    check("rst_halted",      32'(a_if.halted), 32'h0);
    check("rst_count",       a_if.instr_count, 32'h0);
    check("rst_instr",       a_if.instr,       32'h0);
    check("rst_imm",         a_if.imm_sext,    32'h0);
    #1 rst_n = 1'b1;

    // Straight-line program ending in a halt word
    load_a(0, 32'h0000_0000);
    load_a(1, 32'h0400_0000);
    load_a(2, 32'h0800_0000);
    load_a(3, 32'hFC00_0000);
    check("load_valid", 32'(a_if.instr_valid), 32'h0);
    check("load_pc",    a_if.pc,               32'h0);
    start_a();
    check("run_valid",  32'(a_if.instr_valid), 32'h1);
    check("run_pc0",    a_if.pc,               32'h0);
    check("run_op0",    32'(a_if.Opcode),      32'h0);
    // Write during RUN must be dropped (would plant a halt at word 2)
    a_if.prog_we = 1'b1; a_if.prog_addr = 6'd2; a_if.prog_data = 32'hFC00_0000;
    step();
    a_if.prog_we = 1'b0;
    check("run_pc4",    a_if.pc,               32'h4);
    check("run_op1",    32'(a_if.Opcode),      32'h1);
    check("run_cnt1",   a_if.instr_count,      32'h1);
    step();
    check("run_pc8",    a_if.pc,               32'h8);
    check("run_op2",    32'(a_if.Opcode),      32'h2);
    step();
    check("run_pc12",   a_if.pc,               32'hC);
    check("run_op3f",   32'(a_if.Opcode),      32'h3F);
    check("run_cnt3",   a_if.instr_count,      32'h3);
    step();
    check("halt_flag",  32'(a_if.halted),      32'h1);
    check("halt_pc",    a_if.pc,               32'hC);
    check("halt_cnt",   a_if.instr_count,      32'h3);
    check("halt_valid", 32'(a_if.instr_valid), 32'h0);
    check("halt_instr", a_if.instr,            32'h0);
    // HALT ignores writes and run
    a_if.prog_we = 1'b1; a_if.prog_addr = 6'd0; a_if.prog_data = 32'hDEAD_BEEF;
    a_if.run = 1'b1;
    step();
    a_if.prog_we = 1'b0; a_if.run = 1'b0;
    check("halt_hold_flag", 32'(a_if.halted), 32'h1);
    check("halt_hold_pc",   a_if.pc,          32'hC);
    check("halt_hold_cnt",  a_if.instr_count, 32'h3);

    // Memory survives reset and was untouched by the RUN/HALT writes
    do_reset();
    check("mem_rst_halted", 32'(a_if.halted), 32'h0);
    check("mem_rst_instr",  a_if.instr,       32'h0);
    step();
    start_a();
    check("mem_word0", a_if.instr, 32'h0000_0000);
    step();
    check("mem_word1", a_if.instr, 32'h0400_0000);
    step();
    check("mem_word2", a_if.instr, 32'h0800_0000);

    // Taken forward branch: 4 -> 16
    do_reset();
    step();
    load_a(1, 32'h0C00_0002);
    load_a(4, 32'hFC00_0000);
    start_a();
    step();
    check("br_pc4",   a_if.pc,       32'h4);
    check("br_imm",   a_if.imm_sext, 32'h2);
    a_if.Branch = 1'b1; a_if.Zero = 1'b1;
    step();
    a_if.Branch = 1'b0; a_if.Zero = 1'b0;
    check("br_taken_pc", a_if.pc,             32'h10);
    check("br_op3f",     32'(a_if.Opcode),    32'h3F);
    step();
    check("br_halted",   32'(a_if.halted),    32'h1);
    check("br_halt_pc",  a_if.pc,             32'h10);
    check("br_halt_cnt", a_if.instr_count,    32'h2);

    // Branch with Zero = 0 falls through: 4 -> 8
    do_reset();
    step();
    start_a();
    step();
    a_if.Branch = 1'b1; a_if.Zero = 1'b0;
    step();
    a_if.Branch = 1'b0;
    check("br_not_taken_pc", a_if.pc, 32'h8);

    // Backward branch: 0 -> 20, then 20 -> 8 (halt)
    do_reset();
    step();
    load_a(0, 32'h0C00_0004);
    load_a(5, 32'h0C65_FFFC);
    load_a(2, 32'hFC00_0000);
    a_if.Branch = 1'b1; a_if.Zero = 1'b1;
    start_a();
    check("bk_pc0",    a_if.pc,          32'h0);
    step();
    check("bk_pc20",   a_if.pc,          32'h14);
    check("bk_imm",    a_if.imm_sext,    32'hFFFF_FFFC);
    check("bk_plus4",  a_if.pc_plus4,    32'h18);
    check("bk_rs",     32'(a_if.rs),     32'h3);
    check("bk_rt",     32'(a_if.rt),     32'h5);
    check("bk_rd",     32'(a_if.rd),     32'h1F);
    check("bk_funct",  32'(a_if.funct),  32'h3C);
    step();
    check("bk_pc8",    a_if.pc,          32'h8);
    check("bk_cnt",    a_if.instr_count, 32'h2);
    step();
    a_if.Branch = 1'b0; a_if.Zero = 1'b0;
    check("bk_halted", 32'(a_if.halted), 32'h1);
    check("bk_halt_pc", a_if.pc,         32'h8);

    // Asynchronous reset between clock edges
    do_reset();
    step();
    load_a(0, 32'h0);
    load_a(1, 32'h0);
    load_a(2, 32'h0);
    load_a(3, 32'hFC00_0000);
    start_a();
    step();
    step();
    check("ar_pre_pc",  a_if.pc,          32'h8);
    check("ar_pre_cnt", a_if.instr_count, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_pc",     a_if.pc,               32'h0);
    check("ar_valid",  32'(a_if.instr_valid), 32'h0);
    check("ar_cnt",    a_if.instr_count,      32'h0);
    check("ar_halted", 32'(a_if.halted),      32'h0);
    #1 rst_n = 1'b1;

    // Run off the end of a 4-word memory
    step();
    load_b(0, 32'h0);
    load_b(1, 32'h0);
    load_b(2, 32'h0);
    load_b(3, 32'h0);
    check("end_load_valid", 32'(b_if.instr_valid), 32'h0);
    b_if.run = 1'b1;
    step();
    b_if.run = 1'b0;
    step();
    step();
    step();
    check("end_pc12",   b_if.pc,               32'hC);
    check("end_valid",  32'(b_if.instr_valid), 32'h1);
    check("end_cnt3",   b_if.instr_count,      32'h3);
    step();
    check("end_halted", 32'(b_if.halted),      32'h1);
    check("end_pc",     b_if.pc,               32'hC);
    check("end_cnt4",   b_if.instr_count,      32'h4);
    step();
    check("end_hold_pc",  b_if.pc,          32'hC);
    check("end_hold_cnt", b_if.instr_count, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the single-cycle control unit. Holds the PC and a loadable instruction memory, and presents the current instruction each cycle.
- Splits the instruction into Opcode (feeds the control unit), register fields, funct and a sign-extended immediate.
- Computes the next PC from the Branch control output and the ALU Zero flag.
- A small LOAD/RUN/HALT state machine handles program loading, execution and termination.

Parameters:
IMEM_DEPTH, 64, number of 32-bit instruction words; power of two, at least 4
RESET_PC, 32'h0000_0000, PC value loaded on reset; word-aligned
HALT_OPCODE, 6'h3F, opcode that stops fetch

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
prog_we  in  1  instruction memory write strobe; honoured only in LOAD
prog_addr  in  $clog2(IMEM_DEPTH)  word address for program load
prog_data  in  32  instruction word to write
run  in  1  leave LOAD and start execution
Branch  in  1  branch control from the control unit
Zero  in  1  ALU zero flag
pc  out  32  current PC
pc_plus4  out  32  pc + 4
instr  out  32  current instruction; 0 when instr_valid = 0
instr_valid  out  1  high only in RUN; downstream gates RFWE and DMWE with it
Opcode  out  6  instr[31:26]
rs  out  5  instr[25:21]
rt  out  5  instr[20:16]
rd  out  5  instr[15:11]
funct  out  6  instr[5:0]
imm_sext  out  32  sign-extended instr[15:0]
halted  out  1  high in HALT
instr_count  out  32  retired-instruction counter

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All state registers clear on the falling edge of rst_n, independent of clk.
- Reset values:
  - state = LOAD, pc = RESET_PC, instr_count = 0, halted = 0, instr_valid = 0.
  - instr and all derived fields read 0.
  - Memory contents are not reset.
- State LOAD:
  - prog_we = 1 writes prog_data to imem[prog_addr] at the clock edge.
  - run = 1 moves to RUN on the next edge; pc stays RESET_PC.
  - prog_we and run in the same cycle: the write completes and the state changes on that edge.
- State RUN:
  - instr = imem[pc[2+AW-1:2]] as a combinational read, where AW = $clog2(IMEM_DEPTH). There is zero-latency fetch to decode, i.e. single-cycle.
  - next_pc = (Branch & Zero) ? pc_plus4 + (imm_sext << 2) : pc_plus4.
  - All PC arithmetic is 32-bit modulo (wraps); pc[1:0] is always 0.
  - Each edge: pc <= next_pc and instr_count <= instr_count + 1. The counter saturates at 32'hFFFF_FFFF.
  - prog_we is ignored.
- RUN to HALT transitions:
  - Opcode == HALT_OPCODE: on the next edge, state becomes HALT. pc holds the halt instruction's address. The halt instruction is not counted.
  - next_pc[31:2] >= IMEM_DEPTH (out of range): on the next edge, state becomes HALT. The current instruction is counted. pc is not updated and keeps the last valid address.
  - If both conditions hold in the same cycle, the halt-opcode rule wins.
- State HALT:
  - halted = 1, instr_valid = 0, instr = 0.
  - pc and instr_count freeze.
  - run and prog_we are ignored. Only rst_n exits HALT.
- Reset mid-operation: asserting rst_n = 0 in any state immediately returns to the reset values. A partially loaded program remains in memory.
- Branch and Zero are sampled only in RUN; elsewhere they are don't-care.

Decomposition:
- Shared package (mips_pkg):
  - State encoding: LOAD = 2'd0, RUN = 2'd1, HALT = 2'd2.
  - HALT_OPCODE.
  - Instruction field bit positions.
  - Opcode constants Rtype = 0, Lw = 1, Sw = 2, Branch = 3, shared with the control unit.
- One natural sub-module, imem_rf: an IMEM_DEPTH x 32 array with a synchronous write port and an asynchronous read port.
- PC register, next-PC adder, field split and FSM live in the top.

Test Plan:
1. Reset then load: load words 0..3 = {Rtype, Lw, Sw, 32'hFC00_0000}, pulse run. Expected: pc steps 0, 4, 8, 12, then halted = 1 with pc = 12 and instr_count = 3. Opcode sequence is 0, 1, 2.
2. Taken branch: word 1 = 32'h0C00_0002 (Branch, imm = 2), Branch = 1, Zero = 1. Expected: pc goes 4 -> 16. With Zero = 0, pc goes 4 -> 8.
3. Backward branch: word 5 has imm = 16'hFFFC, Branch = Zero = 1. Expected: pc goes 20 -> 8, and imm_sext = 32'hFFFF_FFFC.
4. Run-off end: IMEM_DEPTH = 4, no halt word. Expected: pc reaches 12, then halted = 1, pc stays 12, instr_count = 4.
5. Writes ignored outside LOAD: prog_we pulsed during RUN and during HALT. Expected: memory is unchanged; after reset the contents still read as originally loaded.
6. Async reset mid-run: drop rst_n between clock edges at pc = 8. Expected: pc = 0, instr_valid = 0 and instr_count = 0 immediately, without waiting for a clk edge.
